// File: rtl/machdemxuong4bit_pkg.sv
// Shared definitions for the 4-bit counter family: control state encoding and
// the active-low hex 7-segment table used by both up and down counters.
package machdemxuong4bit_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Segment bits are {g,f,e,d,c,b,a}, 0 = lit; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/machdemxuong4bit_hex7seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex7seg
    import machdemxuong4bit_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[val];

endmodule

// File: rtl/machdemxuong4bit.sv
// Loadable 4-bit down counter with wrap/one-shot modes, terminal-count pulse
// and hex 7-segment output; IDLE/RUN/DONE lets logic tell "never started" from "finished".
module machdemxuong4bit
    import machdemxuong4bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             busy,
    output logic [6:0]       seg
);

    logic [1:0] state;

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            state <= IDLE;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (state == 2'b11) begin
                state <= IDLE;
            end else if (load) begin
                q     <= d;
                state <= RUN;
            end else if (en && state != DONE) begin
                if (!mode) begin
                    q     <= q - WIDTH'(1);
                    state <= RUN;
                    tc    <= (q == WIDTH'(1));
                end else if (q != '0) begin
                    q     <= q - WIDTH'(1);
                    state <= (q == WIDTH'(1)) ? DONE : RUN;
                    tc    <= (q == WIDTH'(1));
                end else begin
                    // One-shot started at zero: expire without a terminal pulse.
                    state <= DONE;
                end
            end
        end
    end

    assign zero = (q == '0);
    assign busy = (state == RUN);

    hex7seg u_hex7seg (
        .val (q),
        .seg (seg)
    );

endmodule

// File: tb/tb_machdemxuong4bit.sv
// Self-checking bench: directed vector table for the listed scenarios, then
// random stimulus compared against a behavioural countdown model.
module tb_machdemxuong4bit;

    logic       clk = 1'b0;
    logic       reset, en, load, mode;
    logic [3:0] d;
    logic [3:0] q;
    logic       zero, tc, busy;
    logic [6:0] seg;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    machdemxuong4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .load  (load),
        .d     (d),
        .mode  (mode),
        .q     (q),
        .zero  (zero),
        .tc    (tc),
        .busy  (busy),
        .seg   (seg)
    );

    typedef struct {
        logic       rst, ld, en, md;
        logic [3:0] d;
        logic [3:0] q;
        logic       tc, busy;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] seg_ref [16];

    // Reference model: count value plus lifecycle phase 0=never started, 1=running, 2=expired
    int m_q, m_ph, m_tc;

    function automatic vec_t mk(logic r, logic l, logic e, logic m, logic [3:0] dv,
                                logic [3:0] eq, logic et, logic eb);
        vec_t v;
        v.rst = r; v.ld = l; v.en = e; v.md = m; v.d = dv;
        v.q = eq; v.tc = et; v.busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic e,
                              input logic m, input logic [3:0] dv);
        if (r) begin
            m_q = 0; m_ph = 0; m_tc = 0;
        end else if (l) begin
            m_q = int'(dv); m_ph = 1; m_tc = 0;
        end else if (e && m_ph != 2) begin
            if (!m) begin
                m_tc = (m_q == 1) ? 1 : 0;
                m_q  = (m_q + 15) % 16;
                m_ph = 1;
            end else if (m_q > 0) begin
                m_tc = (m_q == 1) ? 1 : 0;
                m_q  = m_q - 1;
                m_ph = (m_q == 0) ? 2 : 1;
            end else begin
                m_tc = 0; m_ph = 2;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e,
                         input logic m, input logic [3:0] dv);
        @(negedge clk);
        reset = r; load = l; en = e; mode = m; d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eq,
                                 input logic et, input logic eb);
        chk({tag, ".q"},    7'(q),    7'(eq));
        chk({tag, ".tc"},   7'(tc),   7'(et));
        chk({tag, ".busy"}, 7'(busy), 7'(eb));
        chk({tag, ".zero"}, 7'(zero), 7'(eq == 4'h0));
        chk({tag, ".seg"},  seg,      seg_ref[eq]);
    endtask

    initial begin
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; d = 4'h0;

        //                 rst ld en md  d      q     tc busy
        // Reset overrides load and en
        vecs.push_back(mk(1, 1, 1, 0, 4'h7, 4'h0, 0, 0));
        // Wrap mode from 3: 2,1,0,F,E with tc only at 0
        vecs.push_back(mk(0, 1, 0, 0, 4'h3, 4'h3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hF, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hE, 0, 1));
        // One-shot from 2: stops at 0 in DONE, single tc
        vecs.push_back(mk(0, 1, 0, 1, 4'h2, 4'h2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h0, 0, 0));
        // DONE ignores en even in wrap mode
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 0, 0));
        // Pause
        vecs.push_back(mk(0, 1, 0, 0, 4'h5, 4'h5, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h4, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'h4, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'h4, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h3, 0, 1));
        // Load collides with 1->0 decrement: load wins, no tc
        vecs.push_back(mk(0, 1, 0, 0, 4'h1, 4'h1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 4'h9, 4'h9, 0, 1));
        // One-shot from reset without load: DONE, no tc; then load A
        vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'hA, 4'hA, 0, 1));
        // Reset mid-count, then wrap from IDLE at 0 gives F with no tc
        vecs.push_back(mk(0, 1, 0, 0, 4'h6, 4'h6, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 4'h0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hF, 0, 1));
        // Mode switch mid-count takes effect at next decrement
        vecs.push_back(mk(0, 1, 0, 1, 4'h2, 4'h2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].md, vecs[i].d);
            check_outputs($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc, vecs[i].busy);
        end

        // Random phase against the behavioural model
        drive(1, 0, 0, 0, 4'h0);
        model_step(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 400; i++) begin
            logic r, l, e, m;
            logic [3:0] dv;
            r  = ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 2) == 0);
            dv = 4'($urandom_range(0, 15));
            drive(r, l, e, m, dv);
            model_step(r, l, e, m, dv);
            check_outputs($sformatf("rnd%0d", i), 4'(m_q), m_tc[0], (m_ph == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/machdemxuong4bit.md
# machdemxuong4bit

Loadable 4-bit down counter with wrap and one-shot modes, terminal-count pulse and on-board 7-segment display output. It is the down-counting companion to the team's free-running 4-bit up counter and serves the same board-level role: timers, countdown displays, and loop counters on Xilinx lab boards. The control FSM distinguishes idle, running and expired states so downstream logic can tell "never started" from "finished".

## Interface
- `WIDTH`, 4, counter width; only 4 is supported because the 7-segment decoder is hex.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; one decrement per cycle while high.
- `load`  in  1  synchronous load of `d`; has priority over `en`.
- `d`  in  4  load value.
- `mode`  in  1  0 = wrap (0 -> F), 1 = one-shot (stop at 0).
- `q`  out  4  current count (registered).
- `zero`  out  1  high when `q == 0` (combinational from `q`).
- `tc`  out  1  registered one-cycle pulse on a 1 -> 0 decrement.
- `busy`  out  1  high in state RUN.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}, hex digit of `q`.

## Operation
- Reset, sampled on `clk` only: `q`=0, state IDLE, `tc`=0. The derived outputs are `busy`=0, `zero`=1 and `seg`=7'b1000000 ("0"). Reset overrides `load` and `en`.
- States:
  - IDLE: after reset; nothing has been loaded or counted.
  - RUN: counting or paused.
  - DONE: a one-shot count has expired.
- Priority in every state: reset > load > en > hold.
- `load`=1:
  - `q` <= `d`, state <= RUN, `tc` <= 0.
  - Loading `d`=0 still enters RUN.
- `en`=1 in IDLE or RUN:
  - Wrap mode: `q` <= `q`-1 mod 16, state <= RUN.
  - One-shot mode with `q` != 0: `q` <= `q`-1. The state becomes DONE when the new `q` is 0, otherwise RUN.
  - One-shot mode with `q` == 0: `q` holds, state <= DONE, no `tc`.
- `tc` <= 1 exactly when a decrement takes `q` from 1 to 0, in either mode; otherwise `tc` <= 0. A wrap from 0 to F does not pulse `tc`.
- `en`=1 in DONE: no change. DONE is left only by `load` or `reset`.
- `en`=0: `q` and the state hold, `tc` <= 0.
- `mode` is sampled every cycle. Changing it mid-count takes effect at the next decrement.
- Arithmetic is modulo 2^4. There is no borrow output; `tc` serves as the cascade strobe.

## Timing
- Single clock domain; all state changes occur at the rising edge of `clk`.
- Latency from `load` or `en` to `q` is 1 cycle.
- `tc` is registered and is high in the same cycle that `q` first reads 0.
- `zero`, `busy` and `seg` are combinational from registers and are valid in the same cycle as `q`. They are glitch-free only at the register boundary; board pins must tolerate this.
- Continuous `en` in wrap mode from `q`=3 gives `q` = 2, 1, 0, F, E, … on successive cycles, with `tc` high only in the cycle where `q`=0.
- If `load` and a 1 -> 0 decrement would coincide, `load` wins and `tc` stays 0.

## Structure
- Shared package/header:
  - State encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - The 16-entry active-low hex segment table, so the up and down counters share it.
- Sub-module `hex7seg`: purely combinational 4-bit to 7-segment decoder, instantiated once on `q`. It is reusable by the up counter.
- Top level:
  - One always block for the `q`, state and `tc` registers.
  - Continuous assigns for `zero` and `busy`.
  - The illegal state 2'b11 recovers to IDLE on the next clock, with `q` held.

## Test plan
- Reset with `load`=1 and `en`=1 held → `q`=0, `busy`=0, `zero`=1, `tc`=0, `seg`=7'b1000000.
- Load `d`=3 in wrap mode, then `en`=1 for 5 cycles → `q` = 3, 2, 1, 0, F, E. `tc` is high only when `q`=0, and `busy` stays 1.
- Load `d`=2 in one-shot mode, then `en`=1 for 4 cycles → `q` = 2, 1, 0, 0, 0. State is DONE, `busy`=0, `tc` is a single pulse.
- Pause and collision:
  - Load `d`=5, then `en`=1, 0, 0, 1 → `q` = 5, 4, 4, 4, 3.
  - With `q`=1 and `en`=1, assert `load` with `d`=9 → `q`=9 and `tc`=0.
- After reset, one-shot mode with `en`=1 and no load → `q` stays 0, state DONE, `tc` never asserts. A following load `d`=A gives `busy`=1 and `seg`=7'b0001000.
- Reset asserted mid-count at `q`=6 → next cycle `q`=0 and state IDLE, and `en` is ignored during reset.
